// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow definitions for the CPU front end: run-state encoding,
// default address width and the flow-select code used by the decoder and the
// next-PC stage.
package cpu_ctrl_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int DEPTH_W_DEF     = 3;

    // Run/halt/fault state of the instruction sequencer.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    // Which source feeds the next program counter.
    typedef enum logic [2:0] {
        FLOW_SEQ  = 3'd0,
        FLOW_BR   = 3'd1,
        FLOW_JMP  = 3'd2,
        FLOW_CALL = 3'd3,
        FLOW_RET  = 3'd4,
        FLOW_HOLD = 3'd5
    } flow_e;

endpackage

// File: rtl/return_address_stack.sv
// Hardware return-address stack: a small register array addressed by the
// occupancy count. Push writes at index depth, pop exposes index depth-1.
// Push takes precedence if both are requested; requests that would overflow
// or underflow the stack are ignored here and reported by the caller.
module return_address_stack
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int DEPTH_W     = DEPTH_W_DEF
) (
    input  logic               Clk,
    input  logic               Clear,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int                 PTR_W     = $clog2(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    logic [WIDTH-1:0]   mem_q [STACK_DEPTH];
    logic [WIDTH-1:0]   mem_d [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Status flags, pointers and the visible top-of-stack entry.
    always_comb begin
        full   = (depth_q == DEPTH_MAX);
        empty  = (depth_q == '0);
        wr_ptr = PTR_W'(depth_q);
        rd_ptr = PTR_W'(depth_q - DEPTH_ONE);
        top    = empty ? '0 : mem_q[rd_ptr];
        depth  = depth_q;
    end

    // Next array contents and occupancy for a guarded push or pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        mem_d   = mem_q;
        depth_d = depth_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr] = push_data;
            depth_d       = depth_q + DEPTH_ONE;
        end else if (do_pop) begin
            depth_d = depth_q - DEPTH_ONE;
        end
    end

    // Stack registers; Clear wipes every entry as well as the count.
    always_ff @(posedge Clk or posedge Clear) begin
        // NOTE: the array is reset explicitly because a cleared CPU must not
        // return to stale addresses; this keeps it in flops rather than RAM.
        if (Clear) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            depth_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples values from before this edge.
            mem_q   <= mem_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/next_pc_logic.sv
// Next-PC generation stage. Picks the address the PC register loads on the
// next edge from sequential, branch, jump, call and return flow, owns the
// return-address stack, and runs the RUN/HALTED/FAULT sequencer state.
module next_pc_logic
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int DEPTH_W     = DEPTH_W_DEF
) (
    input  logic               Clk,
    input  logic               Clear,
    input  logic [WIDTH-1:0]   PC,
    input  logic               Stall,
    input  logic               Branch,
    input  logic [WIDTH-1:0]   Offset,
    input  logic               Jump,
    input  logic               Call,
    input  logic               Ret,
    input  logic               Halt,
    input  logic [WIDTH-1:0]   Target,
    output logic [WIDTH-1:0]   Next_PC,
    output logic               Halted,
    output logic               Overflow,
    output logic               Underflow,
    output logic [DEPTH_W-1:0] Depth
);

    state_e             state_q;
    state_e             state_d;
    logic               overflow_q;
    logic               overflow_d;
    logic               underflow_q;
    logic               underflow_d;
    flow_e              flow;
    logic               ras_push;
    logic               ras_pop;
    logic [WIDTH-1:0]   ras_top;
    logic               ras_full;
    logic               ras_empty;
    logic [WIDTH-1:0]   pc_inc;

    return_address_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_ras (
        .Clk       (Clk),
        .Clear     (Clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .depth     (Depth),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Priority decode of control requests into a flow select, stack action
    // and next sequencer state. Stack misuse traps into FAULT.
    always_comb begin
        state_d     = state_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        flow        = FLOW_SEQ;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        if (Clear) begin
            // Registers are held in reset; the PC just sees its increment.
            flow = FLOW_SEQ;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (Stall) begin
                        flow = FLOW_HOLD;
                    end else if (Halt) begin
                        flow    = FLOW_HOLD;
                        state_d = ST_HALTED;
                    end else if (Ret) begin
                        if (ras_empty) begin
                            flow        = FLOW_HOLD;
                            underflow_d = 1'b1;
                            state_d     = ST_FAULT;
                        end else begin
                            flow    = FLOW_RET;
                            ras_pop = 1'b1;
                        end
                    end else if (Call) begin
                        if (ras_full) begin
                            flow       = FLOW_HOLD;
                            overflow_d = 1'b1;
                            state_d    = ST_FAULT;
                        end else begin
                            flow     = FLOW_CALL;
                            ras_push = 1'b1;
                        end
                    end else if (Jump) begin
                        flow = FLOW_JMP;
                    end else if (Branch) begin
                        flow = FLOW_BR;
                    end else begin
                        flow = FLOW_SEQ;
                    end
                end
                default: begin
                    // HALTED and FAULT freeze the PC until Clear.
                    flow = FLOW_HOLD;
                end
            endcase
        end
    end

    // Next address mux. Offset is added at full width, which in modulo
    // 2^WIDTH arithmetic is the same as adding its sign-extended value.
    always_comb begin
        pc_inc  = PC + WIDTH'(1);
        Next_PC = pc_inc;
        case (flow)
            FLOW_SEQ:  Next_PC = pc_inc;
            FLOW_BR:   Next_PC = pc_inc + Offset;
            FLOW_JMP:  Next_PC = Target;
            FLOW_CALL: Next_PC = Target;
            FLOW_RET:  Next_PC = ras_top;
            FLOW_HOLD: Next_PC = PC;
            default:   Next_PC = PC;
        endcase
    end

    // Sequencer state and sticky stack-misuse flags.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state_q     <= ST_RUN;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Status outputs.
    always_comb begin
        Halted    = (state_q != ST_RUN);
        Overflow  = overflow_q;
        Underflow = underflow_q;
    end

endmodule

// File: tb/tb_next_pc_logic.sv
// Self-checking bench for next_pc_logic. Each step drives one cycle of
// stimulus, queues the expected outputs, and compares them shortly before
// the next rising edge. Depth and flag expectations describe the state left
// by earlier cycles; Next_PC describes the current inputs.
module tb_next_pc_logic;

    logic       Clk;
    logic       Clear;
    logic [7:0] PC;
    logic       Stall;
    logic       Branch;
    logic [7:0] Offset;
    logic       Jump;
    logic       Call;
    logic       Ret;
    logic       Halt;
    logic [7:0] Target;
    logic [7:0] Next_PC;
    logic       Halted;
    logic       Overflow;
    logic       Underflow;
    logic [2:0] Depth;

    // Control vector order: {Stall, Halt, Ret, Call, Jump, Branch}.
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_STALL  = 6'b100000;
    localparam logic [5:0] C_HALT   = 6'b010000;
    localparam logic [5:0] C_RET    = 6'b001000;
    localparam logic [5:0] C_CALL   = 6'b000100;
    localparam logic [5:0] C_JUMP   = 6'b000010;
    localparam logic [5:0] C_BRANCH = 6'b000001;

    typedef struct {
        string      tag;
        logic [7:0] npc;
        logic [2:0] depth;
        logic       halted;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    next_pc_logic dut (
        .Clk       (Clk),
        .Clear     (Clear),
        .PC        (PC),
        .Stall     (Stall),
        .Branch    (Branch),
        .Offset    (Offset),
        .Jump      (Jump),
        .Call      (Call),
        .Ret       (Ret),
        .Halt      (Halt),
        .Target    (Target),
        .Next_PC   (Next_PC),
        .Halted    (Halted),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Depth     (Depth)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] npc, input logic [2:0] depth,
                              input logic halted, input logic ovf, input logic unf);
        exp_t e;
        e.tag    = tag;
        e.npc    = npc;
        e.depth  = depth;
        e.halted = halted;
        e.ovf    = ovf;
        e.unf    = unf;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".npc"},    32'(Next_PC),   32'(e.npc));
        check({e.tag, ".depth"},  32'(Depth),     32'(e.depth));
        check({e.tag, ".halted"}, 32'(Halted),    32'(e.halted));
        check({e.tag, ".ovf"},    32'(Overflow),  32'(e.ovf));
        check({e.tag, ".unf"},    32'(Underflow), 32'(e.unf));
    endtask

    task automatic apply(input string tag, input logic [7:0] pc_v, input logic [5:0] ctl,
                         input logic [7:0] off_v, input logic [7:0] tgt_v,
                         input logic [7:0] e_npc, input logic [2:0] e_depth,
                         input logic e_halt, input logic e_ovf, input logic e_unf);
        @(negedge Clk);
        PC     = pc_v;
        {Stall, Halt, Ret, Call, Jump, Branch} = ctl;
        Offset = off_v;
        Target = tgt_v;
        expect_out(tag, e_npc, e_depth, e_halt, e_ovf, e_unf);
        #2;
        compare_front();
    endtask

    // Assert Clear part-way through a cycle with a jump pending; everything
    // must reset at once and Next_PC must be PC+1 from PC=0.
    task automatic clear_mid(input string tag);
        @(posedge Clk);
        #3;
        Clear  = 1'b1;
        PC     = 8'h00;
        {Stall, Halt, Ret, Call, Jump, Branch} = C_JUMP;
        Target = 8'hAA;
        expect_out(tag, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        compare_front();
        @(negedge Clk);
        Clear = 1'b0;
        {Stall, Halt, Ret, Call, Jump, Branch} = C_NONE;
    endtask

    initial begin
        Clear  = 1'b1;
        PC     = 8'h00;
        {Stall, Halt, Ret, Call, Jump, Branch} = C_NONE;
        Offset = 8'h00;
        Target = 8'h00;

        clear_mid("reset");

        // Sequential and branch arithmetic.
        apply("seq_wrap",  8'hFF, C_NONE,   8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("br_fwd",    8'h10, C_BRANCH, 8'h05, 8'h00, 8'h16, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("br_back",   8'h10, C_BRANCH, 8'hF0, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("br_neg4",   8'h02, C_BRANCH, 8'hFC, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);

        // Nested call/return.
        apply("call1",     8'h10, C_CALL,   8'h00, 8'h40, 8'h40, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("call2",     8'h45, C_CALL,   8'h00, 8'h80, 8'h80, 3'd1, 1'b0, 1'b0, 1'b0);
        apply("ret1",      8'h80, C_RET,    8'h00, 8'h00, 8'h46, 3'd2, 1'b0, 1'b0, 1'b0);
        apply("ret2",      8'h46, C_RET,    8'h00, 8'h00, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0);
        apply("after_ret", 8'h11, C_NONE,   8'h00, 8'h00, 8'h12, 3'd0, 1'b0, 1'b0, 1'b0);

        // Priority.
        apply("stall_call", 8'h20, C_STALL | C_CALL, 8'h00, 8'h50, 8'h20, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("call_again", 8'h10, C_CALL,           8'h00, 8'h40, 8'h40, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("call_ret",   8'h40, C_CALL | C_RET,   8'h00, 8'h90, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0);
        apply("jmp_br",     8'h30, C_JUMP | C_BRANCH, 8'h05, 8'h77, 8'h77, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("halt",       8'h50, C_HALT,           8'h00, 8'h00, 8'h50, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply($sformatf("halted%0d", i), 8'(8'h60 + i), 6'($urandom_range(1, 63)),
                  8'($urandom), 8'($urandom), 8'(8'h60 + i), 3'd0, 1'b1, 1'b0, 1'b0);
        end

        // Clear while HALTED with two entries on the stack.
        clear_mid("clear_pre");
        apply("h_call1",   8'h10, C_CALL,  8'h00, 8'h40, 8'h40, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("h_call2",   8'h45, C_CALL,  8'h00, 8'h80, 8'h80, 3'd1, 1'b0, 1'b0, 1'b0);
        apply("h_halt",    8'h80, C_HALT,  8'h00, 8'h00, 8'h80, 3'd2, 1'b0, 1'b0, 1'b0);
        apply("h_hold",    8'h80, C_JUMP,  8'h00, 8'h22, 8'h80, 3'd2, 1'b1, 1'b0, 1'b0);
        clear_mid("clear_halted");

        // Overflow: fill the stack, then one call too many.
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("fill%0d", i), 8'(8'h20 + i), C_CALL, 8'h00, 8'(8'h30 + i),
                  8'(8'h30 + i), 3'(i), 1'b0, 1'b0, 1'b0);
        end
        apply("ovf_call",  8'h33, C_CALL,  8'h00, 8'h90, 8'h33, 3'd4, 1'b0, 1'b0, 1'b0);
        apply("ovf_jump",  8'h33, C_JUMP,  8'h00, 8'h55, 8'h33, 3'd4, 1'b1, 1'b1, 1'b0);
        apply("ovf_ret",   8'h33, C_RET,   8'h00, 8'h00, 8'h33, 3'd4, 1'b1, 1'b1, 1'b0);
        clear_mid("clear_ovf");

        // Underflow: return with an empty stack.
        apply("unf_ret",   8'h20, C_RET,   8'h00, 8'h00, 8'h20, 3'd0, 1'b0, 1'b0, 1'b0);
        apply("unf_jump",  8'h20, C_JUMP,  8'h00, 8'h55, 8'h20, 3'd0, 1'b1, 1'b0, 1'b1);
        clear_mid("clear_unf");
        apply("final_seq", 8'h7F, C_NONE,  8'h00, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
